// File: rtl/user_obi_xbar_demux.sv
// rtl/user_obi_xbar_demux.sv - OBI 1:NumSbr address demux with internal error subordinate and in-order tracking.
// Optional USER_OBI_DEMUX_ERR_LOG_EN adds err_addr_o / err_cnt_o error logging.
module user_obi_xbar_demux #(
  parameter int unsigned NumSbr    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned MaxTrans  = 4,
  parameter logic [NumSbr-1:0][AddrWidth-1:0] SbrStart = {32'h2000_1000, 32'h2000_0000},
  parameter logic [NumSbr-1:0][AddrWidth-1:0] SbrEnd   = {32'h2000_2000, 32'h2000_1000},
  parameter logic [DataWidth-1:0] ErrRdata = 32'hBADC_AB1E
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          mgr_req_i,
  output logic                          mgr_gnt_o,
  input  logic [AddrWidth-1:0]          mgr_addr_i,
  input  logic                          mgr_we_i,
  input  logic [DataWidth/8-1:0]        mgr_be_i,
  input  logic [DataWidth-1:0]          mgr_wdata_i,
  input  logic [IdWidth-1:0]            mgr_aid_i,
  output logic                          mgr_rvalid_o,
  output logic [DataWidth-1:0]          mgr_rdata_o,
  output logic                          mgr_err_o,
  output logic [IdWidth-1:0]            mgr_rid_o,
  output logic [NumSbr-1:0]             sbr_req_o,
  input  logic [NumSbr-1:0]             sbr_gnt_i,
  output logic [AddrWidth-1:0]          sbr_addr_o,
  output logic                          sbr_we_o,
  output logic [DataWidth/8-1:0]        sbr_be_o,
  output logic [DataWidth-1:0]          sbr_wdata_o,
  output logic [IdWidth-1:0]            sbr_aid_o,
  input  logic [NumSbr-1:0]             sbr_rvalid_i,
  input  logic [NumSbr*DataWidth-1:0]   sbr_rdata_i,
  input  logic [NumSbr-1:0]             sbr_err_i,
  input  logic [NumSbr*IdWidth-1:0]     sbr_rid_i
`ifdef USER_OBI_DEMUX_ERR_LOG_EN
  ,
  output logic [AddrWidth-1:0]          err_addr_o,
  output logic [15:0]                   err_cnt_o
`endif
);

  localparam int unsigned SelW = $clog2(NumSbr + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam logic [SelW-1:0] ErrSel = SelW'(NumSbr);

  logic [SelW-1:0]    sel_q, target;
  logic [CntW-1:0]    cnt_q;
  logic               err_valid_q;
  logic [IdWidth-1:0] err_rid_q;
  logic               can_issue, hs, rsp_valid, fwd;

  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_wdata_o = mgr_wdata_i;
  assign sbr_aid_o   = mgr_aid_i;

  // Descending scan so the lowest matching index wins on overlapping windows.
  always_comb begin
    target = ErrSel;
    for (int i = int'(NumSbr) - 1; i >= 0; i--) begin
      if (mgr_addr_i >= SbrStart[i] && mgr_addr_i < SbrEnd[i]) target = SelW'(i);
    end
  end

  assign can_issue = (cnt_q < CntW'(MaxTrans)) && (cnt_q == '0 || target == sel_q);

  always_comb begin
    sbr_req_o = '0;
    mgr_gnt_o = 1'b0;
    if (!rst_i && mgr_req_i && can_issue) begin
      if (target == ErrSel) begin
        mgr_gnt_o = 1'b1;
      end else begin
        for (int i = 0; i < int'(NumSbr); i++) begin
          if (target == SelW'(i)) begin
            sbr_req_o[i] = 1'b1;
            mgr_gnt_o    = sbr_gnt_i[i];
          end
        end
      end
    end
  end

  assign hs = mgr_req_i && mgr_gnt_o;

  always_comb begin
    rsp_valid   = 1'b0;
    mgr_rdata_o = '0;
    mgr_err_o   = 1'b0;
    mgr_rid_o   = '0;
    if (sel_q == ErrSel) begin
      rsp_valid = err_valid_q;
      if (err_valid_q) begin
        mgr_rdata_o = ErrRdata;
        mgr_err_o   = 1'b1;
        mgr_rid_o   = err_rid_q;
      end
    end else begin
      for (int i = 0; i < int'(NumSbr); i++) begin
        if (sel_q == SelW'(i)) begin
          rsp_valid   = sbr_rvalid_i[i];
          mgr_rdata_o = sbr_rdata_i[i*DataWidth +: DataWidth];
          mgr_err_o   = sbr_err_i[i];
          mgr_rid_o   = sbr_rid_i[i*IdWidth +: IdWidth];
        end
      end
    end
  end

  // Responses with nothing outstanding are spurious and never reach the manager.
  assign fwd          = rsp_valid && (cnt_q != '0) && !rst_i;
  assign mgr_rvalid_o = fwd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q       <= ErrSel;
      cnt_q       <= '0;
      err_valid_q <= 1'b0;
      err_rid_q   <= '0;
    end else begin
      if (hs) sel_q <= target;
      case ({hs, fwd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      err_valid_q <= hs && (target == ErrSel);
      if (hs && target == ErrSel) err_rid_q <= mgr_aid_i;
    end
  end

`ifdef USER_OBI_DEMUX_ERR_LOG_EN
  logic [AddrWidth-1:0] err_addr_q;
  logic [15:0]          err_cnt_q;
  logic [16:0]          err_inc, err_sum;

  always_comb begin
    err_inc = {16'd0, hs && (target == ErrSel)};
    for (int i = 0; i < int'(NumSbr); i++) begin
      if (sbr_rvalid_i[i] && !(sel_q == SelW'(i) && cnt_q != '0)) err_inc = err_inc + 17'd1;
    end
    err_sum = {1'b0, err_cnt_q} + err_inc;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (hs && target == ErrSel) err_addr_q <= mgr_addr_i;
      err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;
`endif

endmodule

// File: tb/tb_user_obi_xbar_demux.sv
// tb/tb_user_obi_xbar_demux.sv - directed scoreboard bench for user_obi_xbar_demux.
module tb_user_obi_xbar_demux;
  logic        clk = 1'b0;
  logic        rst;
  logic        mreq, mgnt, mwe, mrvalid, merr, mrid, maid;
  logic [31:0] maddr, mwdata, mrdata;
  logic [3:0]  mbe;
  logic [1:0]  sreq, sgnt, srv, serr, srid;
  logic [31:0] saddr, swdata;
  logic        swe, said;
  logic [3:0]  sbe;
  logic [63:0] srdata;
`ifdef USER_OBI_DEMUX_ERR_LOG_EN
  logic [31:0] err_addr;
  logic [15:0] err_cnt;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  user_obi_xbar_demux dut (
    .clk_i(clk), .rst_i(rst),
    .mgr_req_i(mreq), .mgr_gnt_o(mgnt), .mgr_addr_i(maddr), .mgr_we_i(mwe),
    .mgr_be_i(mbe), .mgr_wdata_i(mwdata), .mgr_aid_i(maid),
    .mgr_rvalid_o(mrvalid), .mgr_rdata_o(mrdata), .mgr_err_o(merr), .mgr_rid_o(mrid),
    .sbr_req_o(sreq), .sbr_gnt_i(sgnt), .sbr_addr_o(saddr), .sbr_we_o(swe),
    .sbr_be_o(sbe), .sbr_wdata_o(swdata), .sbr_aid_o(said),
    .sbr_rvalid_i(srv), .sbr_rdata_i(srdata), .sbr_err_i(serr), .sbr_rid_i(srid)
`ifdef USER_OBI_DEMUX_ERR_LOG_EN
    , .err_addr_o(err_addr), .err_cnt_o(err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rsp(input logic [31:0] d, input logic e, input logic id);
    return {30'd0, d, e, id};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Response scoreboard: every forwarded response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && mrvalid) begin
      if (exp_q.size() == 0) check("unexpected_rvalid", {63'd0, mrvalid}, 64'd0);
      else check("response", {30'd0, mrdata, merr, mrid}, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; mreq = 0; maddr = 0; mwe = 0; mbe = 4'hF; mwdata = 0; maid = 0;
    sgnt = 0; srv = 0; srdata = 0; serr = 0; srid = 0;
    smp();
    check("rst_gnt", {63'd0, mgnt}, 64'd0);
    check("rst_rvalid", {63'd0, mrvalid}, 64'd0);
    check("rst_err", {63'd0, merr}, 64'd0);
    check("rst_rdata", {32'd0, mrdata}, 64'd0);
    check("rst_rid", {63'd0, mrid}, 64'd0);
    check("rst_sreq", {62'd0, sreq}, 64'd0);
    nxt(); rst = 1'b0;

    // Read to sbr0, response two cycles after grant
    nxt(); mreq = 1; maddr = 32'h2000_0004; maid = 0; sgnt = 2'b01;
    smp(); check("t1_sreq", {62'd0, sreq}, 64'd1); check("t1_gnt", {63'd0, mgnt}, 64'd1);
    exp_q.push_back(rsp(32'h1234, 1'b0, 1'b0));
    nxt(); mreq = 0; sgnt = 0;
    smp(); check("t1_idle", {63'd0, mrvalid}, 64'd0);
    nxt(); srv = 2'b01; srdata[31:0] = 32'h1234;
    smp();
    nxt(); srv = 0;

    // Unmapped read: error subordinate answers exactly one cycle later
    mreq = 1; maddr = 32'h3000_0000; maid = 1;
    smp(); check("t2_gnt", {63'd0, mgnt}, 64'd1); check("t2_sreq", {62'd0, sreq}, 64'd0);
    exp_q.push_back(rsp(32'hBADC_AB1E, 1'b1, 1'b1));
    nxt(); mreq = 0; maid = 0;
    smp(); check("t2_rvalid", {63'd0, mrvalid}, 64'd1);
    nxt();
    smp(); check("t2_single", {63'd0, mrvalid}, 64'd0);

    // Fill MaxTrans on sbr1, the fifth request stalls until a response returns
    for (int k = 0; k < 4; k++) begin
      nxt(); mreq = 1; maddr = 32'h2000_1000 + 32'(4 * k); maid = k[0]; sgnt = 2'b10;
      smp(); check("t3_gnt", {63'd0, mgnt}, 64'd1); check("t3_sreq", {62'd0, sreq}, 64'd2);
      exp_q.push_back(rsp(32'hA0 + 32'(k), 1'b0, k[0]));
    end
    nxt(); maddr = 32'h2000_1010; maid = 0;
    smp(); check("t3_full_gnt", {63'd0, mgnt}, 64'd0); check("t3_full_sreq", {62'd0, sreq}, 64'd0);
    nxt(); srv = 2'b10; srdata[63:32] = 32'hA0; srid[1] = 0;
    smp(); check("t3_rsp_cycle_gnt", {63'd0, mgnt}, 64'd0);
    nxt(); srv = 0;
    smp(); check("t3_fifth_gnt", {63'd0, mgnt}, 64'd1);
    exp_q.push_back(rsp(32'hA4, 1'b0, 1'b0));
    nxt(); mreq = 0;
    for (int k = 1; k < 5; k++) begin
      srv = 2'b10; srdata[63:32] = 32'hA0 + 32'(k); srid[1] = k[0];
      smp(); nxt();
    end
    srv = 0;

    // Target switch waits for the outstanding sbr0 response
    mreq = 1; maddr = 32'h2000_0000; sgnt = 2'b11;
    smp(); check("t4_gnt0", {63'd0, mgnt}, 64'd1); check("t4_sreq0", {62'd0, sreq}, 64'd1);
    exp_q.push_back(rsp(32'h55, 1'b0, 1'b0));
    nxt(); maddr = 32'h2000_1008;
    smp(); check("t4_stall_gnt", {63'd0, mgnt}, 64'd0); check("t4_stall_sreq", {62'd0, sreq}, 64'd0);
    nxt(); srv = 2'b01; srdata[31:0] = 32'h55;
    smp(); check("t4_rsp_gnt", {63'd0, mgnt}, 64'd0);
    nxt(); srv = 0;
    smp(); check("t4_gnt1", {63'd0, mgnt}, 64'd1); check("t4_sreq1", {62'd0, sreq}, 64'd2);
    exp_q.push_back(rsp(32'h66, 1'b0, 1'b0));
    nxt(); mreq = 0;
    nxt(); srv = 2'b10; srdata[63:32] = 32'h66; srid = 0;
    smp();
    nxt(); srv = 0;

    // Grant and response in one cycle at cnt=2: exactly two more grants fit afterwards
    mreq = 1; maddr = 32'h2000_0010;
    smp(); check("t5_g0", {63'd0, mgnt}, 64'd1); exp_q.push_back(rsp(32'h70, 1'b0, 1'b0));
    nxt();
    smp(); check("t5_g1", {63'd0, mgnt}, 64'd1); exp_q.push_back(rsp(32'h71, 1'b0, 1'b0));
    nxt(); srv = 2'b01; srdata[31:0] = 32'h70;
    smp(); check("t5_g_and_r", {63'd0, mgnt}, 64'd1); exp_q.push_back(rsp(32'h72, 1'b0, 1'b0));
    nxt(); srv = 0;
    smp(); check("t5_g3", {63'd0, mgnt}, 64'd1); exp_q.push_back(rsp(32'h73, 1'b0, 1'b0));
    nxt();
    smp(); check("t5_g4", {63'd0, mgnt}, 64'd1); exp_q.push_back(rsp(32'h74, 1'b0, 1'b0));
    nxt();
    smp(); check("t5_full", {63'd0, mgnt}, 64'd0);

    // Reset mid-burst with request and a response still pending
    nxt(); rst = 1; srv = 2'b01; srdata[31:0] = 32'h71;
    exp_q.delete();
    smp();
    check("t6_gnt", {63'd0, mgnt}, 64'd0);
    check("t6_sreq", {62'd0, sreq}, 64'd0);
    check("t6_rvalid", {63'd0, mrvalid}, 64'd0);
    check("t6_rdata", {32'd0, mrdata}, 64'd0);
    check("t6_err", {63'd0, merr}, 64'd0);
    check("t6_rid", {63'd0, mrid}, 64'd0);
    nxt(); rst = 0; mreq = 0;
    smp(); check("t6_spurious", {63'd0, mrvalid}, 64'd0);
    nxt(); srv = 0; mreq = 1; maddr = 32'h4000_0000; maid = 1;
    smp(); check("t7_err_g0", {63'd0, mgnt}, 64'd1); exp_q.push_back(rsp(32'hBADC_AB1E, 1'b1, 1'b1));
    nxt(); maddr = 32'h5000_0010; maid = 0;
    smp(); check("t7_err_g1", {63'd0, mgnt}, 64'd1); exp_q.push_back(rsp(32'hBADC_AB1E, 1'b1, 1'b0));
    nxt(); mreq = 0;
    smp();
`ifdef USER_OBI_DEMUX_ERR_LOG_EN
    check("t7_err_cnt", {48'd0, err_cnt}, 64'd3);
    check("t7_err_addr", {32'd0, err_addr}, 64'h5000_0010);
`endif
    nxt(); mreq = 1; maddr = 32'h2000_1000; sgnt = 2'b10;
    smp(); check("t8_gnt", {63'd0, mgnt}, 64'd1); exp_q.push_back(rsp(32'h88, 1'b0, 1'b0));
    nxt(); mreq = 0;
    nxt(); srv = 2'b10; srdata[63:32] = 32'h88; srid = 0;
    smp();
    nxt(); srv = 0;
    smp();
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
